// File: rtl/sd_otf_converter.sv
// Radix-2 on-the-fly converter: MSD-first signed-digit stream to two's complement.
// Q/QM dual registers keep QM == Q-1, so the final value needs no carry-propagate add.
//
// state  | meaning
// IDLE   | waiting for start, digits ignored
// CONV   | accepting digits on d_valid, busy=1
// DONE   | result_valid pulse, result holds final Q
module sd_otf_converter #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       d_valid,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic       busy,
  output logic [N:0] result,
  output logic       result_valid
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [N:0]    r_q;
  logic [N:0]    r_qm;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_valid;
  logic [N:0]    r_result;

  logic          w_pos;
  logic          w_neg;
  logic          w_last;
  logic [N:0]    w_q_nxt;
  logic [N:0]    w_qm_nxt;

  // (1,1) decodes to zero, same as (0,0)
  assign w_pos  = d_plus & ~d_minus;
  assign w_neg  = d_minus & ~d_plus;
  assign w_last = (r_cnt == CW'(N - 1));

  always_comb begin
    w_q_nxt  = {r_q[N-1:0], 1'b0};
    w_qm_nxt = {r_qm[N-1:0], 1'b1};
    if (w_pos) begin
      w_q_nxt  = {r_q[N-1:0], 1'b1};
      w_qm_nxt = {r_q[N-1:0], 1'b0};
    end else if (w_neg) begin
      w_q_nxt  = {r_qm[N-1:0], 1'b1};
      w_qm_nxt = {r_qm[N-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_qm     <= '1;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q     <= '0;
            r_qm    <= '1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          if (start) begin
            r_q   <= '0;
            r_qm  <= '1;
            r_cnt <= '0;
          end else if (d_valid) begin
            r_q   <= w_q_nxt;
            r_qm  <= w_qm_nxt;
            r_cnt <= r_cnt + CW'(1);
            // result is loaded with the final Q so it is valid alongside the pulse
            if (w_last) begin
              r_result <= w_q_nxt;
              r_valid  <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            r_q     <= '0;
            r_qm    <= '1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_sd_otf_converter.sv
// Directed bench for sd_otf_converter: hand-computed results plus a running
// prefix value used to check Q and QM after every accepted digit.
module tb_sd_otf_converter;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       d_valid;
  logic       d_plus;
  logic       d_minus;
  logic       busy;
  logic [N:0] result;
  logic       result_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int model    = 0;
  int model_m1 = 0;

  sd_otf_converter #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .d_valid      (d_valid),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk_v(input string tag, input logic [N:0] obs, input logic [N:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic dv, input logic dp, input logic dm);
    start   = st;
    d_valid = dv;
    d_plus  = dp;
    d_minus = dm;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_prefix(input string tag);
    model_m1 = model - 1;
    chk_v({tag, "_q"}, dut.r_q, model[N:0]);
    chk_v({tag, "_qm"}, dut.r_qm, model_m1[N:0]);
  endtask

  task automatic begin_conv(input logic dv);
    cyc(1'b1, dv, 1'b1, 1'b0);
    model = 0;
    chk_b("start_busy", busy, 1'b1);
    chk_b("start_valid", result_valid, 1'b0);
    chk_prefix("start");
  endtask

  task automatic digit(input logic [1:0] pm, input logic last);
    cyc(1'b0, 1'b1, pm[1], pm[0]);
    model = model * 2 + int'(pm[1]) - int'(pm[0]);
    chk_prefix("digit");
    chk_b("digit_valid", result_valid, last);
    chk_b("digit_busy", busy, ~last);
  endtask

  task automatic stall();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_prefix("stall");
    chk_b("stall_valid", result_valid, 1'b0);
    chk_b("stall_busy", busy, 1'b1);
  endtask

  task automatic stream(input logic [15:0] codes, input logic [N:0] exp_res, input string tag);
    for (int i = 0; i < N; i++) digit(codes[15-2*i -: 2], i == N - 1);
    chk_v(tag, result, exp_res);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    d_valid = 1'b0;
    d_plus = 1'b0;
    d_minus = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_valid", result_valid, 1'b0);
    chk_v("rst_result", result, 9'h000);
    chk_v("rst_q", dut.r_q, 9'h000);
    chk_v("rst_qm", dut.r_qm, 9'h1FF);
    rst = 1'b0;

    // +1 then seven zeros -> 128, pulse in the 10th cycle counting start as 1
    begin_conv(1'b0);
    stream(16'h8000, 9'h080, "res_plus128");
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("idle_valid", result_valid, 1'b0);
    chk_b("idle_busy", busy, 1'b0);
    chk_v("idle_hold", result, 9'h080);

    // all -1; digit offered in the start cycle must not be consumed
    begin_conv(1'b1);
    stream(16'h5555, 9'h101, "res_minus255");

    // alternating with stalls on CONV cycles 3 and 6
    begin_conv(1'b0);
    digit(2'b10, 1'b0);
    digit(2'b01, 1'b0);
    stall();
    digit(2'b10, 1'b0);
    digit(2'b01, 1'b0);
    stall();
    digit(2'b10, 1'b0);
    digit(2'b01, 1'b0);
    digit(2'b10, 1'b0);
    digit(2'b01, 1'b1);
    chk_v("res_alt85", result, 9'h055);

    // -1,+1,(1,1),0,0,0,0,+1 -> -63
    begin_conv(1'b0);
    stream(16'h6C02, 9'h1C1, "res_minus63");

    // abort after four digits; digit in the restart cycle is discarded
    begin_conv(1'b0);
    for (int i = 0; i < 4; i++) digit(2'b10, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    model = 0;
    chk_prefix("abort");
    chk_b("abort_busy", busy, 1'b1);
    chk_b("abort_valid", result_valid, 1'b0);
    chk_v("abort_hold", result, 9'h1C1);
    stream(16'h0002, 9'h001, "res_after_abort");

    // reset mid-conversion discards everything
    begin_conv(1'b0);
    for (int i = 0; i < 5; i++) digit(2'b10, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk_b("midrst_busy", busy, 1'b0);
    chk_b("midrst_valid", result_valid, 1'b0);
    chk_v("midrst_result", result, 9'h000);
    chk_v("midrst_q", dut.r_q, 9'h000);
    chk_v("midrst_qm", dut.r_qm, 9'h1FF);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk_v("idle_ignore_q", dut.r_q, 9'h000);
    chk_b("idle_ignore_busy", busy, 1'b0);
    chk_b("idle_ignore_valid", result_valid, 1'b0);

    // start during DONE: pulse for old operand, new conversion starts at once
    begin_conv(1'b0);
    stream(16'hAAAA, 9'h0FF, "res_plus255");
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    model = 0;
    chk_b("done_start_busy", busy, 1'b1);
    chk_b("done_start_valid", result_valid, 1'b0);
    chk_v("done_start_hold", result, 9'h0FF);
    chk_prefix("done_start");
    stream(16'h0000, 9'h000, "res_zero");
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("final_valid", result_valid, 1'b0);
    chk_b("final_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_otf_converter.md
Name: sd_otf_converter

Overview:
- Radix-2 on-the-fly converter. Consumes an MSD-first signed-digit stream, such as the (plus, minus) digit pairs produced by the team's on-line adder, and rebuilds the conventional two's-complement value.
- Uses the Q/QM dual-register method, so no carry-propagate addition is needed at the end.
- Sits at the output boundary of on-line arithmetic pipelines, where results return to the binary datapath.

Parameters:
- N, 8, number of signed digits per operand (stream length); result width is N+1.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: clear Q/QM and digit counter, begin a new conversion
- d_valid  in  1  digit on d_plus/d_minus is valid this cycle
- d_plus  in  1  positive component of digit
- d_minus  in  1  negative component of digit
- busy  out  1  high while a conversion is in progress (accepting digits)
- result  out  N+1  two's-complement integer equal to sum d_i*2^(N-i), i=1..N
- result_valid  out  1  one-cycle pulse; result updated in the same cycle

Behaviour:
- Digit decode: d = d_plus - d_minus.
  - (1,0) = +1
  - (0,1) = -1
  - (0,0) = 0; (1,1) = 0, legal, no error.
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, result_valid=0, result=0, counter=0, Q=0, QM=all ones. Reset overrides every other input, including mid-conversion; any partial conversion is discarded.
- States:
  - IDLE: busy=0. d_valid is ignored. start -> CONV, with Q=0, QM=all ones (-1) and cnt=0. No digit is consumed in the start cycle.
  - CONV: busy=1. On each cycle with d_valid=1, one digit is accepted (N+1-bit registers, shift left, LSB inserted):
    - d=+1: Q<={Q,1}, QM<={Q,0}
    - d=0: Q<={Q,0}, QM<={QM,1}
    - d=-1: Q<={QM,1}, QM<={QM,0}
    - Counter cnt increments on each accepted digit; d_valid=0 cycles are stalls with no state change.
    - When the N-th digit is accepted (cnt==N-1 and d_valid=1) -> DONE.
  - DONE: result<=Q (final), result_valid=1 for exactly this cycle, busy=0. Next state is IDLE, or CONV if start=1 this cycle.
- Invariant: QM == Q-1 (mod 2^(N+1)) after every accepted digit.
- Latency: result_valid asserts one cycle after the clock edge that accepted the N-th digit. Minimum conversion is N+2 cycles from start to result_valid.
- start in CONV: aborts and restarts (Q/QM/cnt re-cleared). Any digit presented in that cycle is discarded. No result_valid is produced for the aborted operand.
- start in DONE: result_valid still pulses for the completed operand, and the new conversion begins.
- result holds its last value until the next DONE or reset. It is not cleared by start.
- Range: result lies in -(2^N-1) .. +(2^N-1) and always fits in N+1 bits; no overflow is possible.
- Only one operand is in flight at a time; there is no input buffering. The upstream must not present digits before busy=1.

Test Plan:
- Reset, then start, then digits +1,0,0,0,0,0,0,0 (N=8, d_valid held high) -> result=9'h080 (128), result_valid single pulse on cycle 10 after start.
- Eight digits all -1 -> result=9'h101 (-255). Check QM==Q-1 after every digit.
- Alternating +1,-1,+1,-1,+1,-1,+1,-1, with d_valid low on cycles 3 and 6 of CONV -> result=9'h055 (85). Stalls must not shift Q/QM or advance cnt, and result_valid must be delayed by exactly 2 cycles.
- Digits -1,+1,+1,+1,+1,+1,+1,+1 using (1,1) for zero where injected; specifically digits -1,+1,(1,1),0,0,0,0,+1 -> result=-128+64+1 = 9'h1C1 (-63).
- Restart and reset cases:
  - Four digits accepted, then start pulsed again, then 0,0,0,0,0,0,0,+1 -> one result_valid only, result=9'h001.
  - Separately, rst asserted after 5 digits -> busy=0, result=0, no result_valid.
- start asserted in the DONE cycle -> result_valid pulses for the old operand, busy=1 next cycle. A following 8-digit stream of zeros yields result=9'h000.
